// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem read, 1-entry output register.
// Define IFU_STALL_CNT_EN to add the saturating stall_cycles counter port.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction_code,
   output logic [31:0] instr_pc
`ifdef IFU_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_kill, w_kill_nxt;
   logic        r_req, w_req_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic        r_valid, w_valid_nxt;
   logic [31:0] r_code, w_code_nxt;
   logic [31:0] r_ipc, w_ipc_nxt;
   logic [31:0] w_redir_pc;
   logic [31:0] w_tgt_pc;
   logic        w_unused;

   assign w_redir_pc = {redirect_pc[31:2], 2'b00};
   assign w_tgt_pc   = redirect_valid ? w_redir_pc : r_pc;
   assign w_unused   = &{1'b0, redirect_pc[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_kill  <= 1'b0;
         r_req   <= 1'b0;
         r_addr  <= RESET_PC;
         r_valid <= 1'b0;
         r_code  <= NOP_INSTR;
         r_ipc   <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_kill  <= w_kill_nxt;
         r_req   <= w_req_nxt;
         r_addr  <= w_addr_nxt;
         r_valid <= w_valid_nxt;
         r_code  <= w_code_nxt;
         r_ipc   <= w_ipc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_kill_nxt  = r_kill;
      w_req_nxt   = r_req;
      w_addr_nxt  = r_addr;
      w_valid_nxt = r_valid;
      w_code_nxt  = r_code;
      w_ipc_nxt   = r_ipc;
      unique case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_pc;
         end
         S_REQ: begin
            // address stays on the bus until granted, even across a redirect
            if (redirect_valid) begin
               w_pc_nxt   = w_redir_pc;
               w_kill_nxt = 1'b1;
            end
            if (imem_gnt) begin
               w_state_nxt = S_WAIT;
               w_req_nxt   = 1'b0;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (r_kill || redirect_valid) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
                  w_req_nxt   = 1'b1;
                  w_pc_nxt    = w_tgt_pc;
                  w_addr_nxt  = w_tgt_pc;
               end else begin
                  w_code_nxt  = imem_rdata;
                  w_ipc_nxt   = r_pc;
                  w_valid_nxt = 1'b1;
                  w_pc_nxt    = r_pc + 32'd4;
                  w_state_nxt = S_HOLD;
               end
            end else if (redirect_valid) begin
               w_pc_nxt   = w_redir_pc;
               w_kill_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid || instr_ready) begin
               w_valid_nxt = 1'b0;
               w_code_nxt  = NOP_INSTR;
               w_state_nxt = S_REQ;
               w_req_nxt   = 1'b1;
               w_pc_nxt    = w_tgt_pc;
               w_addr_nxt  = w_tgt_pc;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign imem_req         = r_req;
   assign imem_addr        = r_addr;
   assign instr_valid      = r_valid;
   assign instruction_code = r_code;
   assign instr_pc         = r_ipc;

`ifdef IFU_STALL_CNT_EN
   logic [31:0] r_stall;
   logic        w_stall_inc;

   assign w_stall_inc = (r_req && !imem_gnt)
                     || (r_state == S_WAIT && !imem_rvalid);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= 32'h0;
      end else if (w_stall_inc && (r_stall != 32'hFFFF_FFFF)) begin
         r_stall <= r_stall + 32'd1;
      end
   end

   assign stall_cycles = r_stall;
`endif

endmodule
